mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-ported instruction/data memory between two requesters:
//   port 0 (CPU mem_cmd/mem_addr/write_data) and port 1 (program loader / debug DMA).
//   Arbitrates, latches the winning request and sequences the memory cycle.
//   Returns read data and a one-cycle done pulse to the winner.
//   Sits between the cpu and the RAM in the top level.
// PARAMETERS
//   DATA_W    16  memory word width
//   ADDR_W    9   memory address width (matches mem_addr)
//   READ_LAT  1   memory read latency in cycles (>=1)
//   RR        1   1 = round-robin arbitration, 0 = fixed priority (port 0 wins)
// PORTS
//   clk        in   1       clock, rising edge
//   reset      in   1       synchronous, active-low reset
//   req0/req1  in   1       request, port 0 / port 1
//   cmd0/cmd1  in   2       00 NONE, 01 READ, 10 WRITE, 11 treated as NONE
//   addr0/addr1   in   ADDR_W  request address
//   wdata0/wdata1 in   DATA_W  write data
//   gnt0/gnt1  out  1       high during the ISSUE cycle of that port's transaction
//   done0/done1 out 1       one-cycle pulse in DONE state: transaction complete
//   rdata      out  DATA_W  last completed read data (shared by both ports)
//   busy       out  1       high whenever state != IDLE
//   mem_cmd    out  2       to RAM: NONE/READ/WRITE
//   mem_addr   out  ADDR_W  to RAM
//   write_data out  DATA_W  to RAM
//   read_data  in   DATA_W  from RAM, valid READ_LAT cycles after READ issued
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE; gnt*, done*, busy = 0; mem_cmd=NONE;
//     mem_addr=0; write_data=0; rdata=0; last_winner=1 (so port 0 wins first tie).
//   Request is valid only if req==1 and cmd is READ or WRITE. Invalid requests get no grant.
//   FSM: IDLE -> ISSUE -> [WAIT x READ_LAT, reads only] -> DONE -> IDLE.
//   IDLE: on a posedge with at least one valid request, pick the winner, latch its
//     cmd/addr/wdata, and go to ISSUE. With no valid request, stay in IDLE.
//   Arbitration: a lone valid request wins.
//     RR=1: with both valid, the port other than last_winner wins.
//     RR=0: with both valid, port 0 wins.
//     last_winner updates on every grant.
//   ISSUE (1 cycle): gntN=1; mem_cmd = latched cmd; mem_addr/write_data = latched values.
//     Next state: WRITE -> DONE, READ -> WAIT.
//   WAIT (READ_LAT cycles, cycle counter): mem_cmd=READ; mem_addr held.
//     On the last WAIT edge, capture read_data into rdata; go to DONE.
//   DONE (1 cycle): doneN=1 for the winner only; mem_cmd=NONE; then go to IDLE.
//   mem_cmd is NONE in IDLE and DONE. WRITE is driven for exactly one cycle per write.
//   Latency from the sampling edge: gnt 1 cycle; write done at cycle 2; read done at 2+READ_LAT.
//   rdata is valid with the read's done pulse and holds until the next read completes.
//     Writes never change rdata.
//   Inputs are latched at the grant. Changes to req/cmd/addr/wdata after the grant do not
//     affect the transaction. Dropping req mid-transaction does not abort it.
//   A request held through DONE is re-arbitrated in IDLE (min 1 idle cycle between transactions).
//   Reset mid-transaction: the transaction is abandoned with no done pulse;
//     all outputs take reset values at that edge.
//   gnt0 & gnt1 and done0 & done1 are never high simultaneously.
// TESTING
//   1 Hold reset low for 2 edges -> all outputs 0, mem_cmd=00, busy=0.
//   2 Port 0 READ addr 9'h005, RAM returns 16'hD005 (READ_LAT=1) -> gnt0 at cycle 1,
//     mem_cmd=01 in cycles 1-2, done0 at cycle 3, rdata=16'hD005.
//   3 Port 1 WRITE 9'h1FF/16'hBEEF -> mem_cmd=10 for exactly 1 cycle, done1 at cycle 2;
//     a following port 0 READ 9'h1FF returns 16'hBEEF.
//   4 req0 and req1 held continuously, RR=1 -> grants alternate 0,1,0,1;
//     RR=0 -> port 0 gets every grant and port 1 none.
//   5 reset pulsed low during WAIT -> no done pulse, mem_cmd=00 next cycle;
//     a subsequent read completes normally.
//   6 req0 with cmd=11 or 00 -> no gnt, busy stays 0, mem_cmd=00.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter and cycle sequencer for the single-ported memory
module mem_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int READ_LAT = 1,
  parameter int RR       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        cmd0,
  input  logic [1:0]        cmd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam int              CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic             winner;
  logic             last_winner;
  logic [CNT_W-1:0] wait_cnt;

  logic valid0;
  logic valid1;
  logic pick1;

  always_comb begin
    valid0 = req0 && ((cmd0 == CMD_READ) || (cmd0 == CMD_WRITE));
    valid1 = req1 && ((cmd1 == CMD_READ) || (cmd1 == CMD_WRITE));
    pick1  = 1'b0;
    if (valid0 && valid1)
      pick1 = (RR != 0) ? !last_winner : 1'b0;
    else
      pick1 = valid1;
  end

  // mem_cmd/mem_addr/write_data double as the latched request for the whole transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      winner      <= 1'b0;
      last_winner <= 1'b1;
      wait_cnt    <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      busy        <= 1'b0;
      rdata       <= '0;
      mem_cmd     <= CMD_NONE;
      mem_addr    <= '0;
      write_data  <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid0 || valid1) begin
            state       <= S_ISSUE;
            busy        <= 1'b1;
            winner      <= pick1;
            last_winner <= pick1;
            gnt0        <= !pick1;
            gnt1        <= pick1;
            mem_cmd     <= pick1 ? cmd1   : cmd0;
            mem_addr    <= pick1 ? addr1  : addr0;
            write_data  <= pick1 ? wdata1 : wdata0;
          end
        end
        S_ISSUE: begin
          if (mem_cmd == CMD_WRITE) begin
            state   <= S_DONE;
            mem_cmd <= CMD_NONE;
            done0   <= !winner;
            done1   <= winner;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (wait_cnt == CNT_LAST) begin
            state   <= S_DONE;
            rdata   <= read_data;
            mem_cmd <= CMD_NONE;
            done0   <= !winner;
            done1   <= winner;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_cmd <= CMD_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam logic [1:0] NONE = 2'b00, RD = 2'b01, WR = 2'b10, BAD = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req0, req1;
  logic [1:0]    cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, busy;
  logic [DW-1:0] rdata, write_data, read_data;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;

  logic          fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_busy;
  logic [DW-1:0] fp_rdata, fp_write_data;
  logic [DW-1:0] fp_read_data = '0;
  logic [1:0]    fp_mem_cmd;
  logic [AW-1:0] fp_mem_addr;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .RR(1)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data), .read_data(read_data)
  );

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .RR(0)) dut_fp (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1), .rdata(fp_rdata),
    .busy(fp_busy), .mem_cmd(fp_mem_cmd), .mem_addr(fp_mem_addr),
    .write_data(fp_write_data), .read_data(fp_read_data)
  );

  // Synchronous RAM, one cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_cmd == WR) ram[mem_addr] <= write_data;
    read_data <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    if ((gnt0 && gnt1) || (done0 && done1)) begin
      errors++;
      $display("FAIL exclusive: gnt=%b%b done=%b%b expected one-hot", gnt1, gnt0, done1, done0);
    end
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t           sb_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rd;

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; cmd0 = NONE; cmd1 = NONE;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_rd = '0;
  endtask

  task automatic sb_pop();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got done pulse expected none");
    end else begin
      e = sb_q.pop_front();
      check("done_port", {31'd0, done1}, {31'd0, e.port});
      check("rdata", {16'd0, rdata}, {16'd0, e.rdata});
    end
  endtask

  task automatic run_txn(input logic port, input logic [1:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int gnt_c, output int done_c,
                         output int wr_n, output int rd_n, output int busy_n);
    sb_t e;
    gnt_c = -1; done_c = -1; wr_n = 0; rd_n = 0; busy_n = 0;
    @(negedge clk);
    if (port) begin req1 = 1'b1; cmd1 = cmd; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; cmd0 = cmd; addr0 = addr; wdata0 = wdata; end
    if (cmd == RD || cmd == WR) begin
      e.port = port;
      if (cmd == WR) begin
        ref_mem[addr] = wdata;
        e.rdata = last_rd;
      end else begin
        e.rdata = ref_mem[addr];
        last_rd = ref_mem[addr];
      end
      sb_q.push_back(e);
    end
    for (int c = 1; c <= 10 && done_c < 0; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        if (gnt_c < 0) gnt_c = c;
        // Scramble the request after the grant; the transaction must not notice.
        if (port) begin req1 = 1'b0; cmd1 = NONE; addr1 = ~addr; wdata1 = ~wdata; end
        else      begin req0 = 1'b0; cmd0 = NONE; addr0 = ~addr; wdata0 = ~wdata; end
      end
      if (mem_cmd == WR) wr_n++;
      if (mem_cmd == RD) rd_n++;
      if (busy) busy_n++;
      if (done0 || done1) begin
        done_c = c;
        sb_pop();
      end
    end
    idle_inputs();
  endtask

  typedef struct {
    logic          port;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gnt;
    int            done;
    int            wr;
    int            rd;
    int            busy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int g, d, w, r, b;
    int seq[$];
    int gcyc[$];
    int fp0, fp1;

    vecs[0]  = '{1'b0, RD,   9'h005, 16'h0000,  1,  3, 0, 2, 3};
    vecs[1]  = '{1'b1, WR,   9'h1FF, 16'hBEEF,  1,  2, 1, 0, 2};
    vecs[2]  = '{1'b0, RD,   9'h1FF, 16'h0000,  1,  3, 0, 2, 3};
    vecs[3]  = '{1'b1, RD,   9'h1FF, 16'h0000,  1,  3, 0, 2, 3};
    vecs[4]  = '{1'b0, WR,   9'h000, 16'h1234,  1,  2, 1, 0, 2};
    vecs[5]  = '{1'b1, RD,   9'h000, 16'h0000,  1,  3, 0, 2, 3};
    vecs[6]  = '{1'b0, BAD,  9'h003, 16'h7777, -1, -1, 0, 0, 0};
    vecs[7]  = '{1'b0, NONE, 9'h004, 16'h8888, -1, -1, 0, 0, 0};
    vecs[8]  = '{1'b1, BAD,  9'h005, 16'h9999, -1, -1, 0, 0, 0};
    vecs[9]  = '{1'b0, WR,   9'h0AA, 16'h5555,  1,  2, 1, 0, 2};
    vecs[10] = '{1'b1, RD,   9'h0AA, 16'h0000,  1,  3, 0, 2, 3};

    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = 16'hD000 | 16'(i);
      ref_mem[i] = 16'hD000 | 16'(i);
    end
    last_rd = '0;
    idle_inputs();
    reset = 1'b0;

    // Reset state after two edges with reset low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_done",  {30'd0, done1, done0}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_cmd",   {30'd0, mem_cmd}, 32'd0);
    check("rst_addr",  {23'd0, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, write_data}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].port, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, g, d, w, r, b);
      check($sformatf("v%0d_gnt_cyc", i),  g, vecs[i].gnt);
      check($sformatf("v%0d_done_cyc", i), d, vecs[i].done);
      check($sformatf("v%0d_wr_cycles", i), w, vecs[i].wr);
      check($sformatf("v%0d_rd_cycles", i), r, vecs[i].rd);
      check($sformatf("v%0d_busy_cycles", i), b, vecs[i].busy);
    end

    // Both ports requesting continuously: RR alternates, fixed priority starves port 1.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; cmd0 = RD; cmd1 = RD; addr0 = 9'h010; addr1 = 9'h011;
    fp0 = 0; fp1 = 0;
    for (int c = 1; c <= 40 && seq.size() < 4; c++) begin
      @(negedge clk);
      if (gnt0) seq.push_back(0);
      if (gnt1) seq.push_back(1);
      if (gnt0 || gnt1) gcyc.push_back(c);
      if (fp_gnt0) fp0++;
      if (fp_gnt1) fp1++;
    end
    check("rr_grant_count", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) check($sformatf("rr_order%0d", i), seq[i], i % 2);
    if (gcyc.size() >= 2) check("rr_grant_spacing", gcyc[1] - gcyc[0], 4);
    check("fp_port0_grants", fp0, 4);
    check("fp_port1_grants", fp1, 0);
    do_reset();

    // Reset during WAIT abandons the read.
    @(negedge clk);
    req0 = 1'b1; cmd0 = RD; addr0 = 9'h020;
    @(negedge clk);
    check("ab_gnt0", {31'd0, gnt0}, 32'd1);
    idle_inputs();
    @(negedge clk);
    check("ab_wait_cmd", {30'd0, mem_cmd}, {30'd0, RD});
    reset = 1'b0;
    @(negedge clk);
    check("ab_done", {30'd0, done1, done0}, 32'd0);
    check("ab_cmd",  {30'd0, mem_cmd}, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    last_rd = '0;
    repeat (3) begin
      @(negedge clk);
      check("ab_no_done", {30'd0, done1, done0}, 32'd0);
    end
    run_txn(1'b0, RD, 9'h020, 16'h0000, g, d, w, r, b);
    check("post_ab_gnt_cyc",  g, 1);
    check("post_ab_done_cyc", d, 3);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
